// File: rtl/led_sweep_ctrl_if.sv
// led_sweep_ctrl_if: control and LED-drive bundle of the LED bar sweeper
//   i_en      run (1) / freeze (0) the prescaler and bar position
//   i_mode    0 BOUNCE, 1 WRAP_UP, 2 WRAP_DOWN, 3 HOLD
//   i_speed   prescaler period = max(TICK_DIV >> i_speed, 1)
//   i_bright  PWM duty, 0 = dark, all-ones = full on
//   o_leds    registered LED drive
//   o_pos     current bar position
//   o_tick    one-cycle pulse per step
interface led_sweep_ctrl_if #(
    parameter int N_LEDS   = 16,
    parameter int PWM_BITS = 4
);
    logic                      i_en;
    logic [1:0]                i_mode;
    logic [2:0]                i_speed;
    logic [PWM_BITS-1:0]       i_bright;
    logic [N_LEDS-1:0]         o_leds;
    logic [$clog2(N_LEDS)-1:0] o_pos;
    logic                      o_tick;
    modport master (output i_en, i_mode, i_speed, i_bright, input o_leds, o_pos, o_tick);
    modport slave  (input i_en, i_mode, i_speed, i_bright, output o_leds, o_pos, o_tick);
endinterface

// File: rtl/led_sweep_ctrl.sv
// led_sweep_ctrl: centre-split LED bar sweeper with prescaled steps, sweep modes and PWM brightness
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   bus      led_sweep_ctrl_if.slave: i_en, i_mode, i_speed, i_bright in; o_leds, o_pos, o_tick out
module led_sweep_ctrl #(
    parameter int N_LEDS   = 16,
    parameter int TICK_DIV = 6250000,
    parameter int PWM_BITS = 4
) (
    input logic              i_clk,
    input logic              i_rst_n,
    led_sweep_ctrl_if.slave  bus
);
    localparam int H  = N_LEDS / 2;
    localparam int PB = $clog2(N_LEDS);
    localparam int CW = $clog2(TICK_DIV + 1);
    localparam logic [PB-1:0] TOP = PB'(N_LEDS - 1);
    typedef enum logic {UP, DOWN} dir_t;
    logic [CW-1:0]       presc, shifted, per_m1;
    logic [PB-1:0]       pos, pos_nx;
    dir_t                dir, dir_nx;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [N_LEDS-1:0]   mask, leds;
    logic                step, on, tick;
    // ">=" lets a speed change that shrinks the period below presc fire on the next edge
    always_comb begin
        shifted = CW'(TICK_DIV) >> bus.i_speed;
        per_m1  = (shifted == '0) ? '0 : shifted - CW'(1);
        step    = bus.i_en && (presc >= per_m1);
        on      = (&bus.i_bright) | (pwm_cnt < bus.i_bright);
    end
    // BOUNCE turns at the endpoints so each end is shown only once per pass
    always_comb begin
        pos_nx = pos;
        dir_nx = dir;
        case (bus.i_mode)
            2'd0: begin
                if (dir == UP) begin
                    pos_nx = (pos == TOP) ? pos - PB'(1) : pos + PB'(1);
                    dir_nx = (pos == TOP) ? DOWN : UP;
                end else begin
                    pos_nx = (pos == '0) ? pos + PB'(1) : pos - PB'(1);
                    dir_nx = (pos == '0) ? UP : DOWN;
                end
            end
            2'd1: begin
                pos_nx = (pos == TOP) ? '0 : pos + PB'(1);
                dir_nx = UP;
            end
            2'd2: begin
                pos_nx = (pos == '0) ? TOP : pos - PB'(1);
                dir_nx = DOWN;
            end
            default: ;
        endcase
    end
    // Bar grows outward from the centre split toward pos
    always_comb begin
        mask = '0;
        for (int i = 0; i < N_LEDS; i++)
            mask[i] = (int'(pos) < H) ? (i >= int'(pos) && i < H) : (i >= H && i <= int'(pos));
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc   <= '0;
            pos     <= '0;
            dir     <= UP;
            pwm_cnt <= '0;
            tick    <= 1'b0;
            leds    <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            leds    <= on ? mask : '0;
            tick    <= step;
            if (step) begin
                presc <= '0;
                pos   <= pos_nx;
                dir   <= dir_nx;
            end else begin
                presc <= bus.i_en ? presc + CW'(1) : '0;
            end
        end
    end
    assign bus.o_leds = leds;
    assign bus.o_pos  = pos;
    assign bus.o_tick = tick;
endmodule

// File: tb/tb_led_sweep_ctrl.sv
// tb_led_sweep_ctrl: directed self-checking bench for led_sweep_ctrl
module tb_led_sweep_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   tests = 0;
    int   fails = 0;
    led_sweep_ctrl_if #(.N_LEDS(16), .PWM_BITS(4)) bus ();
    led_sweep_ctrl #(.N_LEDS(16), .TICK_DIV(4), .PWM_BITS(4)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // Waits (bounded) for the next o_tick pulse; n = negedges elapsed
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.o_tick && n < 100);
        if (!bus.o_tick) chk("tick_timeout", 32'(bus.o_tick), 32'd1);
    endtask
    int n, cnt;
    int seq[$];
    initial begin
        bus.i_en = 1'b1;
        bus.i_mode = 2'd0;
        bus.i_speed = 3'd0;
        bus.i_bright = 4'hF;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_pos", 32'(bus.o_pos), 0);
        chk("rst_leds", 32'(bus.o_leds), 0);
        chk("rst_tick", 32'(bus.o_tick), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_tick(n);
        chk("first_tick_lat", n, 4);
        chk("first_pos", 32'(bus.o_pos), 1);
        chk("first_leds", 32'(bus.o_leds), 32'h00FF);
        for (int k = 2; k <= 15; k++) seq.push_back(k);
        for (int k = 14; k >= 0; k--) seq.push_back(k);
        seq.push_back(1);
        foreach (seq[i]) begin
            wait_tick(n);
            chk("bounce_period", n, 4);
            chk("bounce_pos", 32'(bus.o_pos), seq[i]);
            if (i == 0)  chk("leds_pos1", 32'(bus.o_leds), 32'h00FE);
            if (i == 14) chk("leds_pos15", 32'(bus.o_leds), 32'hFF00);
            if (i == 29) chk("leds_pos0", 32'(bus.o_leds), 32'h00FF);
        end
        bus.i_mode = 2'd1;
        repeat (13) wait_tick(n);
        chk("wrap_up_at14", 32'(bus.o_pos), 14);
        wait_tick(n); chk("wrap_up_15", 32'(bus.o_pos), 15);
        wait_tick(n); chk("wrap_up_0", 32'(bus.o_pos), 0);
        wait_tick(n); chk("wrap_up_1", 32'(bus.o_pos), 1);
        bus.i_mode = 2'd2;
        wait_tick(n); chk("wrap_dn_0", 32'(bus.o_pos), 0);
        wait_tick(n); chk("wrap_dn_15", 32'(bus.o_pos), 15);
        wait_tick(n); chk("wrap_dn_14", 32'(bus.o_pos), 14);
        bus.i_mode = 2'd3;
        repeat (3) begin
            wait_tick(n);
            chk("hold_period", n, 4);
            chk("hold_pos", 32'(bus.o_pos), 14);
        end
        bus.i_speed = 3'd2;
        repeat (3) begin
            wait_tick(n);
            chk("speed2_period", n, 1);
        end
        bus.i_speed = 3'd0;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            cnt += int'(bus.o_tick);
        end
        chk("speed0_no_tick", cnt, 0);
        bus.i_speed = 3'd1;
        wait_tick(n); chk("speed_shrink_fire", n, 1);
        wait_tick(n); chk("speed1_period_a", n, 2);
        wait_tick(n); chk("speed1_period_b", n, 2);
        bus.i_en = 1'b0;
        bus.i_mode = 2'd0;
        bus.i_speed = 3'd0;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            cnt += int'(bus.o_tick);
        end
        chk("en0_ticks", cnt, 0);
        chk("en0_pos_held", 32'(bus.o_pos), 14);
        bus.i_en = 1'b1;
        wait_tick(n);
        chk("en1_period", n, 4);
        chk("en1_dir_kept", 32'(bus.o_pos), 13);
        bus.i_bright = 4'd4;
        repeat (2) @(negedge clk);
        cnt = 0;
        repeat (16) begin
            @(negedge clk);
            cnt += int'(bus.o_leds != '0);
        end
        chk("pwm_bright4", cnt, 4);
        bus.i_bright = 4'd0;
        repeat (2) @(negedge clk);
        cnt = 0;
        repeat (16) begin
            @(negedge clk);
            cnt += int'(bus.o_leds != '0);
        end
        chk("pwm_bright0", cnt, 0);
        bus.i_bright = 4'hF;
        repeat (2) @(negedge clk);
        cnt = 0;
        repeat (16) begin
            @(negedge clk);
            cnt += int'(bus.o_leds != '0);
        end
        chk("pwm_brightF", cnt, 16);
        bus.i_mode = 2'd1;
        cnt = 0;
        do begin
            wait_tick(n);
            cnt++;
        end while (bus.o_pos != 4'd9 && cnt < 40);
        chk("reach_pos9", 32'(bus.o_pos), 9);
        repeat (2) @(negedge clk);
        chk("pre_rst_leds", 32'(bus.o_leds), 32'h0300);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_leds", 32'(bus.o_leds), 0);
        chk("async_rst_pos", 32'(bus.o_pos), 0);
        chk("async_rst_tick", 32'(bus.o_tick), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_tick(n);
        chk("restart_lat", n, 4);
        chk("restart_pos", 32'(bus.o_pos), 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
